// File: rtl/dsp_operand_fetch.sv
// dsp_operand_fetch: Wishbone classic read master that fetches a block of
// operands from memory and streams them to the sum stage through a small FIFO.
//
// state | meaning
// IDLE  | waiting for start; bus idle
// ISSUE | bus idle between beats; waits for a free FIFO slot
// REQ   | cyc/stb asserted, single read outstanding, ack timer running
// DRAIN | all words fetched; waiting for the FIFO to empty
module dsp_operand_fetch #(
  parameter int dw         = 32,
  parameter int aw         = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic              wb_clk,
  input  logic              wb_rst,
  input  logic              start,
  input  logic [aw-1:0]     base_addr,
  input  logic [15:0]       word_count,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [aw-1:0]     wbm_adr_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [dw/8-1:0]   wbm_sel_o,
  input  logic [dw-1:0]     wbm_dat_i,
  input  logic              wbm_ack_i,
  input  logic              wbm_err_i,
  output logic [dw-1:0]     data_o,
  output logic              data_valid,
  output logic              data_last,
  input  logic              data_ready
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT - 1);
  localparam logic [aw-1:0] ADR_STEP   = aw'(dw / 8);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    REQ   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t          state;
  logic [15:0]     remaining;
  logic [TW-1:0]   timer;
  logic [dw:0]     fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   fifo_count;
  logic            push;
  logic            pop;
  logic            abort;
  logic            last_beat;

  assign wbm_we_o  = 1'b0;
  assign wbm_sel_o = '1;

  // err wins over a simultaneous ack; the timer only expires on a cycle with no response
  assign push      = (state == REQ) && wbm_ack_i && !wbm_err_i;
  assign abort     = (state == REQ) && (wbm_err_i || (!wbm_ack_i && (timer == '0)));
  assign pop       = data_valid && data_ready;
  assign last_beat = (remaining == 16'd1);

  assign data_valid          = (fifo_count != '0);
  assign {data_last, data_o} = fifo_mem[rd_ptr];

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else if (abort) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {last_beat, wbm_dat_i};
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + CW'(1);
      end else if (pop && !push) begin
        fifo_count <= fifo_count - CW'(1);
      end
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_adr_o <= '0;
      remaining <= '0;
      timer     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            error     <= 1'b0;
            wbm_adr_o <= base_addr;
            remaining <= word_count;
            if (word_count == 16'd0) begin
              done <= 1'b1;
            end else begin
              busy  <= 1'b1;
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (fifo_count < DEPTH_C) begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            timer     <= TIMER_LOAD;
            state     <= REQ;
          end
        end
        REQ: begin
          if (abort) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            error     <= 1'b1;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (push) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_adr_o <= wbm_adr_o + ADR_STEP;
            remaining <= remaining - 16'd1;
            state     <= last_beat ? DRAIN : ISSUE;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        DRAIN: begin
          if (fifo_count == '0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_operand_fetch.sv
// Directed bench for dsp_operand_fetch: negedge Wishbone slave model and
// stream sink, hand-computed expectations per scenario.
module tb_dsp_operand_fetch;

  logic        wb_clk;
  logic        wb_rst;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] word_count;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] wbm_adr_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        wbm_err_i;
  logic [31:0] data_o;
  logic        data_valid;
  logic        data_last;
  logic        data_ready;

  int          n_checks;
  int          n_fail;
  int          acc_cnt;
  int          rx_n;
  int          done_cnt;
  int          err_at;
  int          waited;
  logic        slave_mute;
  logic [31:0] mem_base;
  logic [31:0] adr_log [16];
  logic [31:0] rx_data [16];
  logic        rx_last [16];

  dsp_operand_fetch #(
    .dw(32), .aw(32), .FIFO_DEPTH(2), .TIMEOUT(255)
  ) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .start(start), .base_addr(base_addr),
    .word_count(word_count), .busy(busy), .done(done), .error(error),
    .wbm_adr_o(wbm_adr_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o), .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .data_o(data_o),
    .data_valid(data_valid), .data_last(data_last), .data_ready(data_ready)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  // slave answers in the first REQ cycle; sink logs transfers seen on the next edge
  always @(negedge wb_clk) begin
    if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i && !wbm_err_i && !slave_mute) begin
      if (acc_cnt == err_at) begin
        wbm_err_i = 1'b1;
      end else begin
        wbm_ack_i = 1'b1;
        wbm_dat_i = ((wbm_adr_o - mem_base) >> 2) + 32'd1;
      end
      if (acc_cnt < 16) adr_log[acc_cnt] = wbm_adr_o;
      acc_cnt++;
    end else begin
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
    end
    if (data_valid && data_ready) begin
      if (rx_n < 16) begin
        rx_data[rx_n] = data_o;
        rx_last[rx_n] = data_last;
      end
      rx_n++;
    end
    if (done) done_cnt++;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge wb_clk);
    #1;
  endtask

  task automatic reset_logs();
    acc_cnt  = 0;
    rx_n     = 0;
    done_cnt = 0;
  endtask

  task automatic pulse_start(input logic [31:0] b, input logic [15:0] c);
    base_addr  = b;
    word_count = c;
    start      = 1'b1;
    tick(1);
    start      = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (!done && n < budget) begin
      tick(1);
      n++;
    end
    if (!done) check_val("done_seen", done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    wb_rst     = 1'b0;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    data_ready = 1'b0;
    wbm_ack_i  = 1'b0;
    wbm_err_i  = 1'b0;
    wbm_dat_i  = '0;
    slave_mute = 1'b0;
    err_at     = -1;
    mem_base   = '0;
    reset_logs();
    tick(2);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_error", error, 0);
    check_val("rst_cyc_stb", {wbm_cyc_o, wbm_stb_o}, 0);
    check_val("rst_adr", wbm_adr_o, 0);
    check_val("rst_valid", data_valid, 0);
    check_val("we_sel", {wbm_we_o, wbm_sel_o}, 5'b0_1111);
    wb_rst = 1'b1;
    tick(1);

    // 1: basic 4-word job
    mem_base   = 32'h100;
    data_ready = 1'b1;
    reset_logs();
    pulse_start(32'h100, 16'd4);
    check_val("t1_busy", busy, 1);
    check_val("t1_cyc_c1", wbm_cyc_o, 0);
    tick(1);
    check_val("t1_cyc_c2", {wbm_cyc_o, wbm_stb_o}, 2'b11);
    check_val("t1_adr_c2", wbm_adr_o, 32'h100);
    wait_done(100, waited);
    check_val("t1_busy_end", busy, 0);
    tick(2);
    check_val("t1_acc", acc_cnt, 4);
    for (int i = 0; i < 4; i++) begin
      check_val("t1_adr", adr_log[i], 32'h100 + 32'(4 * i));
      check_val("t1_data", rx_data[i], 32'(i + 1));
      check_val("t1_last", rx_last[i], (i == 3) ? 1 : 0);
    end
    check_val("t1_rx", rx_n, 4);
    check_val("t1_done_cnt", done_cnt, 1);
    check_val("t1_error", error, 0);

    // 2: backpressure fills FIFO, then release
    mem_base   = 32'h0;
    data_ready = 1'b0;
    reset_logs();
    pulse_start(32'h0, 16'd5);
    tick(20);
    check_val("t2_stall_acc", acc_cnt, 2);
    check_val("t2_stall_valid", data_valid, 1);
    check_val("t2_hold_data", {data_last, data_o}, 33'h0_0000_0001);
    check_val("t2_busy", busy, 1);
    data_ready = 1'b1;
    wait_done(100, waited);
    tick(2);
    check_val("t2_rx", rx_n, 5);
    check_val("t2_acc", acc_cnt, 5);
    for (int i = 0; i < 5; i++) begin
      check_val("t2_data", rx_data[i], 32'(i + 1));
      check_val("t2_last", rx_last[i], (i == 4) ? 1 : 0);
    end

    // 3: bus error on third access with one word still queued
    mem_base   = 32'h200;
    data_ready = 1'b0;
    err_at     = 2;
    reset_logs();
    pulse_start(32'h200, 16'd6);
    tick(10);
    check_val("t3_acc_pre", acc_cnt, 2);
    data_ready = 1'b1;
    tick(1);
    data_ready = 1'b0;
    wait_done(50, waited);
    check_val("t3_error", error, 1);
    check_val("t3_busy", busy, 0);
    check_val("t3_cyc", wbm_cyc_o, 0);
    check_val("t3_flushed", data_valid, 0);
    tick(2);
    check_val("t3_done_cnt", done_cnt, 1);
    check_val("t3_rx", rx_n, 1);
    check_val("t3_rx0", rx_data[0], 1);
    err_at     = -1;
    data_ready = 1'b1;
    reset_logs();
    pulse_start(32'h200, 16'd1);
    check_val("t3_err_clr", error, 0);
    wait_done(50, waited);
    tick(2);
    check_val("t3_rerun_rx", rx_n, 1);

    // 4: ack timeout, then zero-length job
    slave_mute = 1'b1;
    reset_logs();
    pulse_start(32'h300, 16'd1);
    tick(1);
    check_val("t4_cyc_c2", wbm_cyc_o, 1);
    tick(250);
    check_val("t4_pre_err", error, 0);
    check_val("t4_pre_cyc", wbm_cyc_o, 1);
    wait_done(20, waited);
    check_val("t4_tmo_cycles", waited, 5);
    check_val("t4_error", error, 1);
    check_val("t4_cyc", wbm_cyc_o, 0);
    check_val("t4_busy", busy, 0);
    slave_mute = 1'b0;
    tick(1);
    reset_logs();
    pulse_start(32'h400, 16'd0);
    check_val("t4_zero_done", done, 1);
    check_val("t4_zero_busy", busy, 0);
    check_val("t4_zero_error", error, 0);
    tick(1);
    check_val("t4_zero_done_end", done, 0);
    tick(3);
    check_val("t4_zero_acc", acc_cnt, 0);

    // 5: address wrap and start while busy
    mem_base   = 32'hFFFF_FFFC;
    data_ready = 1'b1;
    reset_logs();
    pulse_start(32'hFFFF_FFFC, 16'd2);
    tick(1);
    pulse_start(32'h500, 16'd3);
    wait_done(50, waited);
    tick(4);
    check_val("t5_acc", acc_cnt, 2);
    check_val("t5_adr0", adr_log[0], 32'hFFFF_FFFC);
    check_val("t5_adr1", adr_log[1], 32'h0);
    check_val("t5_data", {rx_data[0], rx_data[1]}, {32'd1, 32'd2});
    check_val("t5_done_cnt", done_cnt, 1);
    check_val("t5_busy", busy, 0);

    // 6: reset mid-beat, then a clean job
    mem_base   = 32'h600;
    data_ready = 1'b0;
    reset_logs();
    pulse_start(32'h600, 16'd4);
    tick(3);
    check_val("t6_pre_cyc", wbm_cyc_o, 1);
    check_val("t6_pre_valid", data_valid, 1);
    #2;
    wb_rst = 1'b0;
    #1;
    check_val("t6_rst_cyc_stb", {wbm_cyc_o, wbm_stb_o}, 0);
    check_val("t6_rst_busy", busy, 0);
    check_val("t6_rst_valid", data_valid, 0);
    check_val("t6_rst_adr", wbm_adr_o, 0);
    tick(2);
    check_val("t6_no_done", done_cnt, 0);
    wb_rst     = 1'b1;
    tick(1);
    data_ready = 1'b1;
    reset_logs();
    pulse_start(32'h600, 16'd2);
    wait_done(50, waited);
    tick(2);
    check_val("t6_rx", rx_n, 2);
    check_val("t6_data", {rx_data[0], rx_data[1]}, {32'd1, 32'd2});
    check_val("t6_last", {rx_last[0], rx_last[1]}, 2'b01);
    check_val("t6_error", error, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
